// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the single register-file write port.
// Each source queues into its own FIFO; a round-robin arbiter drains one entry per cycle.
module regfile_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [4:0]            a_reg,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [4:0]            b_reg,
    input  logic [DATA_WIDTH-1:0] b_data,
    output logic                  RegWrite,
    output logic [4:0]            WriteRegister,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic [31:0]           pending,
    output logic                  grant_b
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [4:0]            aRegMem  [DEPTH];
    logic [DATA_WIDTH-1:0] aDataMem [DEPTH];
    logic [4:0]            bRegMem  [DEPTH];
    logic [DATA_WIDTH-1:0] bDataMem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0] aWrPtr, aRdPtr, bWrPtr, bRdPtr;
    logic [PW:0] aCount, bCount;
    logic        aFull, aEmpty, bFull, bEmpty;
    logic        aPush, bPush, popA, popB;
    logic        lastB;
    logic [31:0] pendingMask;
    logic [PW-1:0] aSlot, bSlot;

    assign aFull  = (aWrPtr[PW] != aRdPtr[PW]) && (aWrPtr[PW-1:0] == aRdPtr[PW-1:0]);
    assign bFull  = (bWrPtr[PW] != bRdPtr[PW]) && (bWrPtr[PW-1:0] == bRdPtr[PW-1:0]);
    assign aEmpty = (aWrPtr == aRdPtr);
    assign bEmpty = (bWrPtr == bRdPtr);
    assign aCount = aWrPtr - aRdPtr;
    assign bCount = bWrPtr - bRdPtr;

    assign a_ready = !aFull;
    assign b_ready = !bFull;
    assign aPush   = a_valid && a_ready;
    assign bPush   = b_valid && b_ready;

    // Round robin: on a tie the source not granted last wins.
    assign popA = !aEmpty && (bEmpty || lastB);
    assign popB = !bEmpty && (aEmpty || !lastB);

    // NOTE: storage arrays carry no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (aPush) begin
            aRegMem[aWrPtr[PW-1:0]]  <= a_reg;
            aDataMem[aWrPtr[PW-1:0]] <= a_data;
        end
        if (bPush) begin
            bRegMem[bWrPtr[PW-1:0]]  <= b_reg;
            bDataMem[bWrPtr[PW-1:0]] <= b_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            aWrPtr        <= '0;
            aRdPtr        <= '0;
            bWrPtr        <= '0;
            bRdPtr        <= '0;
            lastB         <= 1'b1;
            RegWrite      <= 1'b0;
            WriteRegister <= '0;
            WriteData     <= '0;
            grant_b       <= 1'b0;
        end else begin
            if (aPush) aWrPtr <= aWrPtr + PTR_ONE;
            if (bPush) bWrPtr <= bWrPtr + PTR_ONE;
            if (popA) begin
                aRdPtr        <= aRdPtr + PTR_ONE;
                RegWrite      <= (aRegMem[aRdPtr[PW-1:0]] != 5'd0);
                WriteRegister <= aRegMem[aRdPtr[PW-1:0]];
                WriteData     <= aDataMem[aRdPtr[PW-1:0]];
                grant_b       <= 1'b0;
                lastB         <= 1'b0;
            end else if (popB) begin
                bRdPtr        <= bRdPtr + PTR_ONE;
                RegWrite      <= (bRegMem[bRdPtr[PW-1:0]] != 5'd0);
                WriteRegister <= bRegMem[bRdPtr[PW-1:0]];
                WriteData     <= bDataMem[bRdPtr[PW-1:0]];
                grant_b       <= 1'b1;
                lastB         <= 1'b1;
            end else begin
                RegWrite      <= 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        pendingMask = '0;
        aSlot       = '0;
        bSlot       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            aSlot = aRdPtr[PW-1:0] + PW'(k);
            bSlot = bRdPtr[PW-1:0] + PW'(k);
            if ((PW+1)'(k) < aCount) pendingMask[aRegMem[aSlot]] = 1'b1;
            if ((PW+1)'(k) < bCount) pendingMask[bRegMem[bSlot]] = 1'b1;
        end
        if (RegWrite) pendingMask[WriteRegister] = 1'b1;
        pendingMask[0] = 1'b0;
    end

    assign pending = pendingMask;
endmodule
